// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline control slice.
package pipeline_ctrl_pkg;

  localparam int unsigned REG_W = 4;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StHalt    = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational RAW hazard detection between ID sources and EX/MEM destinations.
// PIPELINE_FORWARDING_EN selects load-use-only detection; default is full interlock.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic             id_valid,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             two_src,
  input  logic             exe_wb_en,
  input  logic             exe_mem_read,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             mem_wb_en,
  input  logic [REG_W-1:0] mem_dest,
  output logic             hazard
);

`ifdef PIPELINE_FORWARDING_EN
  // MEM results are forwarded, so only a load in EX can stall the consumer.
  logic unused_mem;
  assign unused_mem = ^{mem_wb_en, mem_dest};

  assign hazard = id_valid && exe_mem_read && exe_wb_en &&
                  ((exe_dest == src1) || (two_src && (exe_dest == src2)));
`else
  logic unused_load;
  assign unused_load = exe_mem_read;

  logic src1_hit;
  logic src2_hit;

  assign src1_hit = (exe_wb_en && (exe_dest == src1)) || (mem_wb_en && (mem_dest == src1));
  assign src2_hit = (exe_wb_en && (exe_dest == src2)) || (mem_wb_en && (mem_dest == src2));
  assign hazard   = id_valid && (src1_hit || (two_src && src2_hit));
`endif

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller with memory-wait timeout and stall counter.
// Build option: PIPELINE_FORWARDING_EN (load-use-only hazards).
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned PERF_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  src1,
  input  logic [REG_W-1:0]  src2,
  input  logic              two_src,
  input  logic              exe_wb_en,
  input  logic              exe_mem_read,
  input  logic [REG_W-1:0]  exe_dest,
  input  logic              mem_wb_en,
  input  logic [REG_W-1:0]  mem_dest,
  input  logic              branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              freeze_pc,
  output logic              freeze_if,
  output logic              flush_if,
  output logic              bubble_id,
  output logic              freeze_back,
  output logic              halted,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam int unsigned WaitW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);

  ctrl_state_e       state_q, state_d;
  logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [PERF_W-1:0] stall_q, stall_d;
  logic              hazard;

  hazard_detect u_hazard_detect (
    .id_valid     (id_valid),
    .src1         (src1),
    .src2         (src2),
    .two_src      (two_src),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_read (exe_mem_read),
    .exe_dest     (exe_dest),
    .mem_wb_en    (mem_wb_en),
    .mem_dest     (mem_dest),
    .hazard       (hazard)
  );

  always_comb begin
    freeze_pc   = 1'b0;
    freeze_if   = 1'b0;
    flush_if    = 1'b0;
    bubble_id   = 1'b0;
    freeze_back = 1'b0;
    halted      = 1'b0;
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;

    unique case (state_q)
      StRun: begin
        // Memory wait outranks branch, branch outranks hazard.
        if (mem_req && !mem_ready) begin
          freeze_pc   = 1'b1;
          freeze_if   = 1'b1;
          freeze_back = 1'b1;
          state_d     = StMemWait;
          wait_cnt_d  = WaitW'(1);
        end else if (branch_taken) begin
          flush_if  = 1'b1;
          bubble_id = 1'b1;
        end else if (hazard) begin
          freeze_pc = 1'b1;
          freeze_if = 1'b1;
          bubble_id = 1'b1;
        end
      end
      StMemWait: begin
        freeze_pc   = !mem_ready;
        freeze_if   = !mem_ready;
        freeze_back = !mem_ready;
        if (mem_ready) begin
          state_d = StRun;
        end else if (wait_cnt_q == WaitMax) begin
          state_d = StHalt;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      StHalt: begin
        freeze_pc   = 1'b1;
        freeze_if   = 1'b1;
        freeze_back = 1'b1;
        halted      = 1'b1;
      end
      default: state_d = StRun;
    endcase

    // Reset masks every output, independent of the registered state.
    if (rst) begin
      freeze_pc   = 1'b0;
      freeze_if   = 1'b0;
      flush_if    = 1'b0;
      bubble_id   = 1'b0;
      freeze_back = 1'b0;
      halted      = 1'b0;
    end

    stall_d = stall_q;
    if (freeze_pc && (stall_q != {PERF_W{1'b1}})) begin
      stall_d = stall_q + PERF_W'(1);
    end
  end

  assign stall_cycles = rst ? '0 : stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      stall_q    <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized bench for pipeline_ctrl: two instances (different timeout/counter
// widths) share stimulus and are checked against a behavioural model.
module tb_pipeline_ctrl;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [3:0] src1, src2;
  logic       two_src;
  logic       exe_wb_en, exe_mem_read;
  logic [3:0] exe_dest;
  logic       mem_wb_en;
  logic [3:0] mem_dest;
  logic       branch_taken;
  logic       mem_req, mem_ready;

  logic        a_fpc, a_fif, a_flush, a_bub, a_fback, a_halt;
  logic [3:0]  a_stall;
  logic        b_fpc, b_fif, b_flush, b_bub, b_fback, b_halt;
  logic [15:0] b_stall;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state, index 0 = instance a, 1 = instance b.
  int unsigned tmo[2]  = '{6, 3};
  int unsigned smax[2] = '{15, 65535};
  bit          m_waiting[2];
  bit          m_halt[2];
  int unsigned m_waited[2];
  int unsigned m_stall[2];

  // Samples taken at the falling edge of the last step.
  logic [5:0]  s_flags[2];
  logic [31:0] s_stall[2];

  pipeline_ctrl #(.MEM_TIMEOUT(6), .PERF_W(4)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2), .two_src(two_src),
    .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read), .exe_dest(exe_dest),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .freeze_pc(a_fpc), .freeze_if(a_fif),
    .flush_if(a_flush), .bubble_id(a_bub), .freeze_back(a_fback), .halted(a_halt),
    .stall_cycles(a_stall)
  );

  pipeline_ctrl #(.MEM_TIMEOUT(3), .PERF_W(16)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2), .two_src(two_src),
    .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read), .exe_dest(exe_dest),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .freeze_pc(b_fpc), .freeze_if(b_fif),
    .flush_if(b_flush), .bubble_id(b_bub), .freeze_back(b_fback), .halted(b_halt),
    .stall_cycles(b_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_hazard();
`ifdef PIPELINE_FORWARDING_EN
    return id_valid && exe_mem_read && exe_wb_en &&
           (exe_dest == src1 || (two_src && exe_dest == src2));
`else
    bit h1, h2;
    h1 = (exe_wb_en && exe_dest == src1) || (mem_wb_en && mem_dest == src1);
    h2 = (exe_wb_en && exe_dest == src2) || (mem_wb_en && mem_dest == src2);
    return id_valid && (h1 || (two_src && h2));
`endif
  endfunction

  // Flags order: {freeze_pc, freeze_if, flush_if, bubble_id, freeze_back, halted}
  task automatic step();
    logic [5:0] ef;
    @(negedge clk);
    s_flags[0] = {a_fpc, a_fif, a_flush, a_bub, a_fback, a_halt};
    s_flags[1] = {b_fpc, b_fif, b_flush, b_bub, b_fback, b_halt};
    s_stall[0] = 32'(a_stall);
    s_stall[1] = 32'(b_stall);
    for (int i = 0; i < 2; i++) begin
      ef = 6'b000000;
      if (!rst) begin
        if (m_halt[i])                 ef = 6'b110011;
        else if (m_waiting[i])         ef = mem_ready ? 6'b000000 : 6'b110010;
        else if (mem_req && !mem_ready) ef = 6'b110010;
        else if (branch_taken)         ef = 6'b001100;
        else if (model_hazard())       ef = 6'b110100;
      end
      check($sformatf("flags%0d", i), 32'(s_flags[i]), 32'(ef));
      check($sformatf("stall%0d", i), s_stall[i], rst ? 32'd0 : m_stall[i]);
      if (rst) begin
        m_waiting[i] = 1'b0;
        m_halt[i]    = 1'b0;
        m_waited[i]  = 0;
        m_stall[i]   = 0;
      end else begin
        if (ef[5] && m_stall[i] < smax[i]) m_stall[i]++;
        if (m_halt[i]) begin
        end else if (m_waiting[i]) begin
          if (mem_ready) m_waiting[i] = 1'b0;
          else if (m_waited[i] == tmo[i]) begin
            m_waiting[i] = 1'b0;
            m_halt[i]    = 1'b1;
          end else m_waited[i]++;
        end else if (mem_req && !mem_ready) begin
          m_waiting[i] = 1'b1;
          m_waited[i]  = 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; id_valid = 0; src1 = 0; src2 = 0; two_src = 0; exe_wb_en = 0;
    exe_mem_read = 0; exe_dest = 0; mem_wb_en = 0; mem_dest = 0;
    branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    rst = 0;
  endtask

  initial begin
    idle();
    // Reset with busy inputs: outputs must stay low.
    rst = 1; mem_req = 1; branch_taken = 1; id_valid = 1; exe_wb_en = 1;
    step();
    step();
    check("rst_flags", 32'(s_flags[0]), 32'd0);
    idle();

    // Single-cycle RAW hazard on src1.
    id_valid = 1; src1 = 4'd3; exe_wb_en = 1; exe_dest = 4'd3; src2 = 4'd9;
`ifndef PIPELINE_FORWARDING_EN
    step();
    check("raw_flags", 32'(s_flags[0]), 32'b110100);
    idle();
    step();
    check("raw_count", s_stall[0], 32'd1);
`else
    step();
    check("fwd_nostall", 32'(s_flags[0]), 32'b000000);
    exe_mem_read = 1;
    step();
    check("fwd_loaduse", 32'(s_flags[0]), 32'b110100);
    idle();
    step();
`endif

    // Branch coinciding with a load-use hazard: flush wins.
    id_valid = 1; src1 = 4'd5; exe_wb_en = 1; exe_mem_read = 1; exe_dest = 4'd5;
    branch_taken = 1;
    step();
    check("br_over_hz", 32'(s_flags[0]), 32'b001100);
    idle();

    // Four-cycle memory wait with a branch pulse inside it.
    mem_req = 1; mem_ready = 0;
    for (int k = 0; k < 4; k++) begin
      branch_taken = (k == 2);
      step();
      check("mw_fback", 32'(s_flags[0][1]), 32'd1);
      check("mw_noflush", 32'(s_flags[0][3]), 32'd0);
    end
    branch_taken = 0; mem_ready = 1;
    step();
    check("mw_ready", 32'(s_flags[0]), 32'd0);
    idle();
    step();
    check("mw_run", 32'(s_flags[0]), 32'd0);
    do_reset();

    // Timeout into HALT on instance b, then recover by reset.
    mem_req = 1; mem_ready = 0;
    for (int k = 0; k < 5; k++) step();
    mem_req = 0;
    step();
    check("halt_b", 32'(s_flags[1]), 32'b110011);
    rst = 1;
    step();
    check("halt_rst", 32'(s_flags[1]), 32'd0);
    check("halt_rst_cnt", s_stall[1], 32'd0);
    idle();
    step();
    check("halt_run", 32'(s_flags[1]), 32'd0);

    // Held hazard saturates the 4-bit counter.
    id_valid = 1; src1 = 4'd7; exe_wb_en = 1; exe_mem_read = 1; exe_dest = 4'd7;
    for (int k = 0; k < 20; k++) step();
    idle();
    step();
    check("sat15", s_stall[0], 32'd15);
    check("nosat16", s_stall[1], 32'd20);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      rst          = ($urandom_range(0, 63) == 0);
      id_valid     = $urandom_range(0, 1);
      src1         = 4'($urandom_range(0, 3));
      src2         = 4'($urandom_range(0, 3));
      two_src      = $urandom_range(0, 1);
      exe_wb_en    = $urandom_range(0, 1);
      exe_mem_read = $urandom_range(0, 1);
      exe_dest     = 4'($urandom_range(0, 3));
      mem_wb_en    = $urandom_range(0, 1);
      mem_dest     = 4'($urandom_range(0, 3));
      branch_taken = ($urandom_range(0, 7) == 0);
      mem_req      = ($urandom_range(0, 5) == 0);
      mem_ready    = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
